enc_pwm_mixer: RTL

Parametrised successor to the three-channel encoder/PWM mixer. It provides NUM_CH independent channels, each with its own quadrature rotary encoder and PWM output. Encoder inputs are synchronised and debounced on-chip. Each decoded encoder drives a WIDTH-bit level with run-time selectable wrap or saturate behaviour. The level sets a glitch-free PWM duty cycle, with a shared period-start sync strobe. The block sits in the user project area between the GPIO pads (encoder in, PWM/sync out) and the logic-analyser control bits.

---
 rtl/enc_pwm_mixer_if.sv | 24 ++
 rtl/enc_pwm_mixer.sv | 104 ++++++++++
 2 files changed

// File: rtl/enc_pwm_mixer_if.sv
// Pad/control-side bundle of the encoder/PWM mixer: encoder phases and mode in,
// PWM, period sync, levels and pad enables out.
interface enc_pwm_mixer_if #(
  parameter int NUM_CH = 3,
  parameter int WIDTH  = 8
);
  logic [NUM_CH-1:0]       enc_a;
  logic [NUM_CH-1:0]       enc_b;
  logic                    saturate;
  logic [NUM_CH-1:0]       pwm_out;
  logic                    sync;
  logic [NUM_CH*WIDTH-1:0] level;
  logic [NUM_CH:0]         io_oeb;

  modport master (
    output enc_a, enc_b, saturate,
    input  pwm_out, sync, level, io_oeb
  );

  modport slave (
    input  enc_a, enc_b, saturate,
    output pwm_out, sync, level, io_oeb
  );
endinterface

// File: rtl/enc_pwm_mixer.sv
// NUM_CH quadrature encoders, each debounced and accumulated into a WIDTH-bit level
// that drives a glitch-free PWM channel sharing one period counter and sync strobe.
module enc_pwm_mixer #(
  parameter int NUM_CH  = 3,
  parameter int WIDTH   = 8,
  parameter int STEP    = 1,
  parameter int DEB_DIV = 64
) (
  input logic           clk,
  input logic           reset,
  enc_pwm_mixer_if.slave bus
);
  localparam int PW = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(DEB_DIV - 1);
  localparam logic [WIDTH-1:0] PC_LAST    = {{(WIDTH-1){1'b1}}, 1'b0};
  localparam logic [WIDTH:0]   STEP_X     = (WIDTH+1)'(STEP);

  logic [PW-1:0]     presc;
  logic              tick;
  logic [NUM_CH-1:0] a_meta, a_sync, b_meta, b_sync;
  logic [NUM_CH-1:0] hist_a, hist_b, deb_a, deb_b, deb_a_d;
  logic [NUM_CH-1:0] inc_ev, dec_ev;
  logic [WIDTH-1:0]  pc;
  logic              sync_q;

  assign tick = (presc == PRESC_LAST);

  // A debounced value only replaces deb once two consecutive ticks agree on it.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc   <= '0;
      a_meta  <= '0;
      a_sync  <= '0;
      b_meta  <= '0;
      b_sync  <= '0;
      hist_a  <= '0;
      hist_b  <= '0;
      deb_a   <= '0;
      deb_b   <= '0;
      deb_a_d <= '0;
      inc_ev  <= '0;
      dec_ev  <= '0;
    end else begin
      presc   <= tick ? '0 : presc + 1'b1;
      a_meta  <= bus.enc_a;
      a_sync  <= a_meta;
      b_meta  <= bus.enc_b;
      b_sync  <= b_meta;
      if (tick) begin
        hist_a <= a_sync;
        hist_b <= b_sync;
        deb_a  <= (~(a_sync ^ hist_a) & a_sync) | ((a_sync ^ hist_a) & deb_a);
        deb_b  <= (~(b_sync ^ hist_b) & b_sync) | ((b_sync ^ hist_b) & deb_b);
      end
      deb_a_d <= deb_a;
      inc_ev  <= deb_a & ~deb_a_d & ~deb_b;
      dec_ev  <= deb_a & ~deb_a_d & deb_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= '0;
      sync_q <= 1'b0;
    end else begin
      pc     <= (pc == PC_LAST) ? '0 : pc + 1'b1;
      sync_q <= (pc == '0);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [WIDTH-1:0] lvl;
    logic [WIDTH-1:0] duty;
    logic             pwm_q;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   dif;

    assign sum = {1'b0, lvl} + STEP_X;
    assign dif = {1'b0, lvl} - STEP_X;

    // The carry/borrow bit of the widened result tells saturate mode when to clamp.
    always_ff @(posedge clk) begin
      if (reset) begin
        lvl   <= '0;
        duty  <= '0;
        pwm_q <= 1'b0;
      end else begin
        if (inc_ev[i])
          lvl <= (bus.saturate && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
        else if (dec_ev[i])
          lvl <= (bus.saturate && dif[WIDTH]) ? '0 : dif[WIDTH-1:0];
        if (pc == PC_LAST)
          duty <= lvl;
        pwm_q <= (pc < duty);
      end
    end

    assign bus.level[i*WIDTH +: WIDTH] = lvl;
    assign bus.pwm_out[i]              = pwm_q;
  end

  assign bus.sync   = sync_q;
  assign bus.io_oeb = '0;
endmodule
